// File: rtl/fpu_uart_pkg.sv
// fpu_uart_pkg: shared UART transmitter states, constants and the nibble-to-ASCII helper.
package fpu_uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam int UART_DATA_BITS = 8;
    localparam int MIN_CLKS_PER_BIT = 2;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return nib < 4'd10 ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/fpu_result_uart_tx_if.sv
// fpu_result_uart_tx_if: result input, baud setting and UART/status outputs of the result transmitter.
interface fpu_result_uart_tx_if #(parameter int DATA_W = 16);
    logic [15:0] clks_per_bit;
    logic [DATA_W-1:0] result;
    logic result_valid;
    logic tx;
    logic tx_busy;
    logic fifo_full;
    logic overflow;

    modport master(
        output clks_per_bit, result, result_valid,
        input tx, tx_busy, fifo_full, overflow
    );

    modport slave(
        input clks_per_bit, result, result_valid,
        output tx, tx_busy, fifo_full, overflow
    );
endinterface

// File: rtl/fpu_result_fifo.sv
// fpu_result_fifo: synchronous result FIFO with wrap-bit pointers and a registered full flag.
module fpu_result_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0] wptr, rptr, wnext, rnext;

    assign wnext = wptr + (AW + 1)'(push);
    assign rnext = rptr + (AW + 1)'(pop);
    assign empty = wptr == rptr;
    assign rdata = mem[rptr[AW-1:0]];

    // Pointers advance independently; full is flopped from the next-state pointers so it tracks the current count.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            full <= 1'b0;
        end else begin
            wptr <= wnext;
            rptr <= rnext;
            full <= (wnext ^ rnext) == (AW + 1)'(DEPTH);
        end

    // Storage needs no reset: occupancy is defined only by the pointers.
    always_ff @(posedge clk)
        if (push) mem[wptr[AW-1:0]] <= wdata;
endmodule

// File: rtl/fpu_result_uart_tx.sv
// fpu_result_uart_tx: buffers FPU results and sends them MS byte first as 8N1 UART frames.
// Define FPU_RESULT_HEX_EN to send each word as uppercase ASCII hex followed by CR LF instead of raw bytes.
module fpu_result_uart_tx
    import fpu_uart_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FIFO_DEPTH = 4
) (
    input logic clk,
    input logic rst,
    fpu_result_uart_tx_if.slave bus
);
`ifdef FPU_RESULT_HEX_EN
    localparam int NIBBLES = DATA_W / 4;
    localparam int NBYTES = NIBBLES + 2;
    localparam int SHIFT = 4;
`else
    localparam int NBYTES = DATA_W / 8;
    localparam int SHIFT = 8;
`endif
    localparam int BW = $clog2(NBYTES + 1);

    tx_state_t state;
    logic [15:0] cnt, period, eff_cpb;
    logic [2:0] bit_idx;
    logic [BW-1:0] byte_idx, next_idx;
    logic [DATA_W-1:0] word, src, rdata;
    logic [7:0] sh, next_byte;
    logic full, empty, pop, push, tx, overflow;

    assign pop = state == IDLE && !empty;
    assign push = bus.result_valid && (!full || pop);
    assign eff_cpb = bus.clks_per_bit < 16'(MIN_CLKS_PER_BIT) ? 16'(MIN_CLKS_PER_BIT) : bus.clks_per_bit;
    assign src = state == IDLE ? rdata : word;
    assign next_idx = state == IDLE ? '0 : byte_idx + BW'(1);
`ifdef FPU_RESULT_HEX_EN
    assign next_byte = next_idx < BW'(NIBBLES) ? hex_ascii(src[DATA_W-1 -: 4]) :
                       next_idx == BW'(NIBBLES) ? ASCII_CR : ASCII_LF;
`else
    assign next_byte = src[DATA_W-1 -: 8];
`endif

    assign bus.tx = tx;
    assign bus.tx_busy = state != IDLE || !empty;
    assign bus.fifo_full = full;
    assign bus.overflow = overflow;

    fpu_result_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .wdata(bus.result),
        .rdata(rdata),
        .full(full),
        .empty(empty)
    );

    // Sticky drop flag: a result arrived with no free slot and no pop making room.
    always_ff @(posedge clk or posedge rst)
        if (rst) overflow <= 1'b0;
        else if (bus.result_valid && full && !pop) overflow <= 1'b1;

    // Frame sequencer: each START latches the baud period and the next byte; word bytes run back to back.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            tx <= 1'b1;
            cnt <= '0;
            period <= '0;
            bit_idx <= '0;
            byte_idx <= '0;
            word <= '0;
            sh <= '0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    state <= START;
                    tx <= 1'b0;
                    cnt <= eff_cpb - 16'd1;
                    period <= eff_cpb;
                    sh <= next_byte;
                    word <= src << SHIFT;
                    byte_idx <= next_idx;
                end
                START: if (cnt != '0) cnt <= cnt - 16'd1;
                else begin
                    state <= DATA;
                    tx <= sh[0];
                    sh <= sh >> 1;
                    bit_idx <= '0;
                    cnt <= period - 16'd1;
                end
                DATA: if (cnt != '0) cnt <= cnt - 16'd1;
                else begin
                    cnt <= period - 16'd1;
                    if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
                        state <= STOP;
                        tx <= 1'b1;
                    end else begin
                        tx <= sh[0];
                        sh <= sh >> 1;
                        bit_idx <= bit_idx + 3'd1;
                    end
                end
                STOP: if (cnt != '0) cnt <= cnt - 16'd1;
                else if (byte_idx == BW'(NBYTES - 1)) state <= IDLE;
                else begin
                    state <= START;
                    tx <= 1'b0;
                    cnt <= eff_cpb - 16'd1;
                    period <= eff_cpb;
                    sh <= next_byte;
                    word <= src << SHIFT;
                    byte_idx <= next_idx;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_fpu_result_uart_tx.sv
// tb_fpu_result_uart_tx: scoreboard bench; a word-level timeline model predicts flags and bytes, a line decoder checks the UART output.
module tb_fpu_result_uart_tx;
    localparam int DATA_W = 16;
    localparam int DEPTH = 4;
`ifdef FPU_RESULT_HEX_EN
    localparam int NB = DATA_W / 4 + 2;
`else
    localparam int NB = DATA_W / 8;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    fpu_result_uart_tx_if #(.DATA_W(DATA_W)) bus ();

    fpu_result_uart_tx #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cpb_eff = 4;
    bit chk_flags = 1'b1;
    logic [7:0] exp_q[$];
    logic [DATA_W-1:0] mq[$];
    longint m_k = 0;
    longint m_busy_until = 0;
    bit m_ovf = 1'b0;

    function automatic int eff(input logic [15:0] c);
        return (c < 16'd2) ? 2 : int'(c);
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic void enqueue_word(input logic [DATA_W-1:0] w);
`ifdef FPU_RESULT_HEX_EN
        for (int i = DATA_W / 4 - 1; i >= 0; i--) begin
            logic [3:0] n;
            n = w[i*4 +: 4];
            exp_q.push_back(n < 4'd10 ? 8'h30 + 8'(n) : 8'h41 + 8'(n - 4'd10));
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`else
        for (int i = DATA_W / 8 - 1; i >= 0; i--) exp_q.push_back(w[i*8 +: 8]);
`endif
    endfunction

    // Reference model: FIFO as a queue, transmitter as a busy-until timeline of whole words.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            exp_q.delete();
            m_k = 0;
            m_busy_until = 0;
            m_ovf = 1'b0;
        end else begin
            m_k++;
            if (m_k > m_busy_until && mq.size() != 0) begin
                void'(mq.pop_front());
                m_busy_until = m_k + longint'(NB * 10 * eff(bus.clks_per_bit));
            end
            if (bus.result_valid) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(bus.result);
                    enqueue_word(bus.result);
                end else m_ovf = 1'b1;
            end
        end
    end

    // Status flags compared against the model every cycle.
    always @(negedge clk)
        if (chk_flags) begin
            check("fifo_full", longint'(bus.fifo_full), longint'(mq.size() == DEPTH));
            check("overflow", longint'(bus.overflow), longint'(m_ovf));
            check("tx_busy", longint'(bus.tx_busy), longint'((m_k < m_busy_until) || mq.size() != 0));
        end

    // UART line decoder: samples mid-bit and pops the scoreboard at each stop bit.
    bit mon_busy = 1'b0;
    int mon_cnt = 0;
    int mon_cpb = 2;
    logic [9:0] mon_bits;
    always @(negedge clk) begin
        int j;
        if (rst) mon_busy = 1'b0;
        else if (!mon_busy) begin
            if (bus.tx === 1'b0) begin
                mon_busy = 1'b1;
                mon_cnt = 0;
                mon_cpb = cpb_eff;
            end
        end else mon_cnt++;
        if (mon_busy && mon_cnt >= mon_cpb / 2 && (mon_cnt - mon_cpb / 2) % mon_cpb == 0) begin
            j = (mon_cnt - mon_cpb / 2) / mon_cpb;
            mon_bits[j] = bus.tx;
            if (j == 9) begin
                mon_busy = 1'b0;
                check("start bit", longint'(mon_bits[0]), 0);
                check("stop bit", longint'(mon_bits[9]), 1);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL uart byte: got %0h, required none", mon_bits[8:1]);
                end else check("uart byte", longint'(mon_bits[8:1]), longint'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] w);
        bus.result = w;
        bus.result_valid = 1'b1;
        tick();
        bus.result_valid = 1'b0;
    endtask

    task automatic set_cpb(input int c);
        bus.clks_per_bit = 16'(c);
        cpb_eff = eff(16'(c));
    endtask

    task automatic drain();
        int t = 0;
        while ((bus.tx_busy || mon_busy) && t < 20000) begin
            tick();
            t++;
        end
        check("drain bound", longint'(t < 20000), 1);
        repeat (2) tick();
    endtask

    task automatic wait_low(input string name);
        int t = 0;
        while (bus.tx !== 1'b0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check(name, longint'(t < 2000), 1);
    endtask

    task automatic low_run(input string name, input int req);
        int n = 0;
        while (bus.tx === 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, n, req);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " tx"}, longint'(bus.tx), 1);
        check({tag, " tx_busy"}, longint'(bus.tx_busy), 0);
        check({tag, " fifo_full"}, longint'(bus.fifo_full), 0);
        check({tag, " overflow"}, longint'(bus.overflow), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int n;
        bus.result = '0;
        bus.result_valid = 1'b0;
        set_cpb(4);
        #1 rst = 1'b1;
        repeat (3) tick();
        check_reset_state("reset");
        rst = 1'b0;
        repeat (2) tick();

        // Single word: frame length and busy drop.
        push(16'h3F80);
        wait_low("t1 start seen");
        n = 0;
        while (bus.tx_busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("t1 frame cycles", n, NB * 10 * 4);
        drain();

        // Fill while transmitting, then overflow.
        push(16'hAAAA);
        tick();
        for (int i = 1; i <= 4; i++) push(DATA_W'(i));
        check("t2 full", longint'(bus.fifo_full), 1);
        check("t2 no overflow yet", longint'(bus.overflow), 0);
        push(16'h0005);
        check("t2 overflow", longint'(bus.overflow), 1);
        drain();

        // Async reset during data bit 3.
        push(16'hA5C3);
        wait_low("t4 start seen");
        repeat (17) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_state("mid-frame reset");
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
        push(16'h1234);
        drain();

        // Push into a full FIFO on the pop cycle.
        push(16'h1111);
        tick();
        for (int i = 0; i < 4; i++) push(DATA_W'(16'h2000 + i));
        check("t3 full", longint'(bus.fifo_full), 1);
        t = 0;
        while (m_k != m_busy_until && t < 2000) begin
            tick();
            t++;
        end
        check("t3 pop cycle found", longint'(t < 2000), 1);
        push(16'hBEEF);
        check("t3 overflow stays 0", longint'(bus.overflow), 0);
        check("t3 still full", longint'(bus.fifo_full), 1);
        drain();

`ifdef FPU_RESULT_HEX_EN
        push(16'hC0A5);
        drain();
`endif

        // Randomised traffic at several baud settings.
        for (int r = 0; r < 4; r++) begin
            set_cpb(int'($urandom_range(0, 5)));
            for (int c = 0; c < 400; c++) begin
                bus.result = DATA_W'($urandom);
                bus.result_valid = $urandom_range(0, 9) == 0;
                tick();
            end
            bus.result_valid = 1'b0;
            drain();
        end

        // Baud clamp and mid-byte baud change.
        chk_flags = 1'b0;
        set_cpb(0);
        push(16'hFFFF);
        wait_low("t5 start seen");
        low_run("t5 start len cpb0", 2);
        drain();
        set_cpb(4);
        push(16'hFFFF);
        wait_low("t5 byte0 start seen");
        low_run("t5 byte0 start len", 4);
        repeat (8) @(negedge clk);
        set_cpb(8);
        t = 0;
        while (bus.tx !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        wait_low("t5 byte1 start seen");
        low_run("t5 byte1 start len", 8);
        drain();

        check("leftover bytes", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
